fetch_stage: RTL

- Instruction-fetch stage. It is the producer side of the decode-stage interface.
- Owns the architectural PC, drives the synchronous instruction SRAM, and supplies pc, inst_sram_en and is_in_slot to decode.
- Consumes decode's redirect outputs (branch, jump, jr) and the exception flush.
- SRAM read data returns one cycle after the address, aligned with decode's registered pc.

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 34 +++
 rtl/fetch_stage_npc_gen.sv | 42 ++++
 rtl/fetch_stage.sv | 124 ++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// The optional FETCH_ADEL_EN build uses EXCODE_ADEL to flag misaligned fetches.
package fetch_stage_pkg;

   localparam logic [31:0] BOOT_VECTOR     = 32'hbfc00000;
   localparam logic [31:0] EXC_VECTOR      = 32'hbfc00380;
   localparam logic [31:0] EXC_VECTOR_BEV0 = 32'h80000180;

   localparam int unsigned EXCODE_W    = 8;
   localparam int unsigned EXCODE_ADEL = 0;

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StPend = 2'd2
   } fetch_state_e;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch/decode boundary: redirect inputs from decode and the fetch outputs it consumes.
// master = fetch (producer), slave = decode side.
interface fetch_stage_if;

   logic        stall;
   logic        flush;
   logic [31:0] flush_target;
   logic [31:0] pc_d;
   logic        branch;
   logic [31:0] imm_d;
   logic        jump;
   logic [25:0] instr_index;
   logic        jr;
   logic [31:0] jr_src;
   logic        next_is_in_slot;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] pc;
   logic        is_in_slot;
   logic [7:0]  fetch_excode;

   modport master (
      input  stall, flush, flush_target, pc_d, branch, imm_d, jump, instr_index, jr, jr_src,
             next_is_in_slot,
      output inst_sram_en, inst_sram_addr, pc, is_in_slot, fetch_excode
   );

   modport slave (
      output stall, flush, flush_target, pc_d, branch, imm_d, jump, instr_index, jr, jr_src,
             next_is_in_slot,
      input  inst_sram_en, inst_sram_addr, pc, is_in_slot, fetch_excode
   );

endinterface

// File: rtl/fetch_stage_npc_gen.sv
// Next-PC generation: branch/jump target arithmetic and the redirect priority mux.
// Priority: flush > jr > jump > branch > sequential.
module fetch_stage_npc_gen (
   input  logic [31:0] pc_i,
   input  logic [31:0] pc_d_i,
   input  logic [31:0] imm_d_i,
   input  logic [25:0] instr_index_i,
   input  logic [31:0] jr_src_i,
   input  logic [31:0] flush_target_i,
   input  logic        flush_i,
   input  logic        jr_i,
   input  logic        jump_i,
   input  logic        branch_i,
   output logic [31:0] npc_o,
   output logic        redirect_o
);

   logic [31:0] pc_d_plus4;
   logic [31:0] btarget;
   logic [31:0] jtarget;

   assign pc_d_plus4 = pc_d_i + 32'd4;
   assign btarget    = pc_d_plus4 + (imm_d_i << 2);
   assign jtarget    = {pc_d_plus4[31:28], instr_index_i, 2'b00};

   // Flush is kept out of redirect_o: it bypasses the stall/pending path entirely.
   assign redirect_o = jr_i | jump_i | branch_i;

   always_comb begin
      npc_o = pc_i + 32'd4;
      if (flush_i) begin
         npc_o = flush_target_i;
      end else if (jr_i) begin
         npc_o = jr_src_i;
      end else if (jump_i) begin
         npc_o = jtarget;
      end else if (branch_i) begin
         npc_o = btarget;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM and holds stalled redirects.
// Optional macro FETCH_ADEL_EN enables the misaligned-fetch (AdEL) check.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = BOOT_VECTOR,
   parameter int unsigned PC_W     = 32
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.master bus
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0] pend_target_q, pend_target_d;
   logic            pend_valid_q, pend_valid_d;
   logic            en_q, en_d;
   logic            slot_q, slot_d;
   logic [31:0]     npc;
   logic            redirect;

   fetch_stage_npc_gen u_npc_gen (
      .pc_i           (fetch_pc_q),
      .pc_d_i         (bus.pc_d),
      .imm_d_i        (bus.imm_d),
      .instr_index_i  (bus.instr_index),
      .jr_src_i       (bus.jr_src),
      .flush_target_i (bus.flush_target),
      .flush_i        (bus.flush),
      .jr_i           (bus.jr),
      .jump_i         (bus.jump),
      .branch_i       (bus.branch),
      .npc_o          (npc),
      .redirect_o     (redirect)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StBoot;
         fetch_pc_q    <= RESET_PC;
         pend_target_q <= '0;
         pend_valid_q  <= 1'b0;
         en_q          <= 1'b0;
         slot_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         pend_target_q <= pend_target_d;
         pend_valid_q  <= pend_valid_d;
         en_q          <= en_d;
         slot_q        <= slot_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      pend_target_d = pend_target_q;
      pend_valid_d  = pend_valid_q;
      en_d          = en_q;
      slot_d        = slot_q;
      if (bus.flush) begin
         // Decode squashes the in-flight word itself, so fetch keeps en high.
         state_d      = StRun;
         fetch_pc_d   = bus.flush_target;
         pend_valid_d = 1'b0;
         slot_d       = 1'b0;
         en_d         = 1'b1;
      end else begin
         unique case (state_q)
            StBoot: begin
               state_d = StRun;
               en_d    = 1'b1;
            end
            StRun: begin
               if (!bus.stall) begin
                  fetch_pc_d = npc;
                  slot_d     = bus.next_is_in_slot;
               end else if (redirect) begin
                  // Latch the target now; forwarded operands may change before the stall ends.
                  state_d       = StPend;
                  pend_target_d = npc;
                  pend_valid_d  = 1'b1;
               end
            end
            StPend: begin
               if (!bus.stall) begin
                  state_d      = StRun;
                  pend_valid_d = 1'b0;
                  slot_d       = 1'b0;
                  if (pend_valid_q) begin
                     fetch_pc_d = pend_target_q;
                  end
               end
            end
            default: begin
               state_d = StBoot;
               en_d    = 1'b0;
            end
         endcase
      end
   end

   assign bus.pc             = fetch_pc_q;
   assign bus.inst_sram_addr = fetch_pc_q;
   assign bus.is_in_slot     = slot_q;

`ifdef FETCH_ADEL_EN
   logic misaligned;

   assign misaligned = en_q & is_misaligned(fetch_pc_q);

   always_comb begin
      bus.fetch_excode              = '0;
      bus.fetch_excode[EXCODE_ADEL] = misaligned;
      bus.inst_sram_en              = en_q & ~misaligned;
   end
`else
   assign bus.fetch_excode = '0;
   assign bus.inst_sram_en = en_q;
`endif

endmodule
